uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 153 +++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first.
// The serial line is synchronised and then timed from the detected start edge.
// Each bit is sampled at its nominal midpoint. A byte is delivered only when
// its stop bit samples high. A low stop bit raises a framing-error pulse and
// leaves the output byte unchanged.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       rx,
  output logic [7:0] data,
  output logic       done,
  output logic       busy,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  // Half a bit minus one lands on the start-bit midpoint.
  // A full bit minus one steps from one midpoint to the next.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic             rx_meta_q;
  logic             rx_s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;

  // Two-flop synchroniser for the asynchronous line.
  // Both flops reset to the idle (high) level.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make each flop capture the value its
    // neighbour held before the edge; blocking ones would collapse the chain.
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State register together with the counters, shifter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: bit timing, sampling and frame completion.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        // rx_en gates only the detection of a new start edge.
        if (rx_en && !rx_s_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
          // The start bit must still be low at its midpoint.
          // A high sample means a glitch, so return to IDLE quietly.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          // Return to IDLE at the stop-bit midpoint.
          // This lets a start bit that follows straight after be caught.
          state_d = S_IDLE;
          if (rx_s_q) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign data      = data_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx.
// The stimulus tasks push the expected byte (or expected framing error) onto a
// scoreboard. A negedge monitor pops and compares each done / frame_err pulse.
module tb_uart_rx;

  localparam int N = 16;
  localparam int H = N / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_en;
  logic       rx;
  logic [7:0] data;
  logic       done;
  logic       busy;
  logic       frame_err;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_en    (rx_en),
    .rx       (rx),
    .data     (data),
    .done     (done),
    .busy     (busy),
    .frame_err(frame_err)
  );

  typedef struct {
    logic [7:0] byte_v;
    bit         ferr;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       sb_e;
  int         n_checks      = 0;
  int         n_pass        = 0;
  int         cyc           = 0;
  int         last_done_cyc = -1;
  int         busy_cycles   = 0;
  logic [7:0] last_good     = 8'h00;
  logic [7:0] prev_data     = 8'h00;
  bit         mask_data     = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cycles++;
      if (done || frame_err) begin
        check("done_ferr_exclusive", {31'd0, done & frame_err}, 0);
        if (sb_q.size() == 0) begin
          check("unexpected_event", {30'd0, done, frame_err}, 0);
        end else begin
          sb_e = sb_q.pop_front();
          check("event_is_ferr", {31'd0, frame_err}, {31'd0, sb_e.ferr});
          if (sb_e.ferr) begin
            check("data_hold_on_ferr", {24'd0, data}, {24'd0, last_good});
          end else begin
            check("rx_data", {24'd0, data}, {24'd0, sb_e.byte_v});
            last_good     = sb_e.byte_v;
            last_done_cyc = cyc;
          end
        end
      end
      if (data !== prev_data && !mask_data)
        check("data_changes_only_with_done", {31'd0, done}, 1);
    end
    prev_data = data;
  end

  // Advance n clocks, then step just past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural transmitter: start bit, 8 data bits LSB first, stop bit, idle high.
  task automatic send(input logic [7:0] b, input logic stop_v);
    rx = 1'b0;
    tick(N);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(N);
    end
    rx = stop_v;
    tick(N);
    rx = 1'b1;
  endtask

  task automatic send_exp(input logic [7:0] b);
    exp_t e;
    e.byte_v = b;
    e.ferr   = 1'b0;
    sb_q.push_back(e);
    send(b, 1'b1);
  endtask

  // Wait until the receiver has been idle for two bit times, with a cycle budget.
  task automatic wait_quiet();
    int quiet;
    int budget;
    quiet  = 0;
    budget = 0;
    while (quiet < 2 * N && budget < 4000) begin
      tick(1);
      quiet = busy ? 0 : quiet + 1;
      budget++;
    end
    check("quiet_within_budget", {31'd0, budget < 4000}, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   fall_cyc;
    exp_t e;

    rst   = 1'b1;
    rx    = 1'b1;
    rx_en = 1'b1;
    @(posedge clk);
    #1;
    tick(5);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    check("reset_ferr", {31'd0, frame_err}, 0);
    check("reset_data", {24'd0, data}, 0);
    rst = 1'b0;
    tick(4);

    // Single frame: check its latency from the falling edge.
    fall_cyc = cyc;
    send_exp(8'h6A);
    wait_quiet();
    check("done_latency", last_done_cyc - fall_cyc, 155);
    check("data_after_6A", {24'd0, data}, 32'h6A);

    // Two frames back to back, each with one stop bit.
    send_exp(8'h6A);
    send_exp(8'h5B);
    wait_quiet();
    check("data_after_5B", {24'd0, data}, 32'h5B);

    // A short low glitch on the line must not be taken as a frame.
    busy_cycles = 0;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    check("glitch_busy_le9", {31'd0, busy_cycles <= 9}, 1);
    check("glitch_busy_seen", {31'd0, busy_cycles > 0}, 1);
    check("glitch_data_hold", {24'd0, data}, 32'h5B);

    // Framing error after a good byte.
    send_exp(8'h6A);
    e.byte_v = 8'h3C;
    e.ferr   = 1'b1;
    sb_q.push_back(e);
    send(8'h3C, 1'b0);
    wait_quiet();
    check("ferr_data_kept", {24'd0, data}, 32'h6A);

    // Reset pulsed during data bit 4. Bits 4..7 of 0xF3 are high, so the
    // rest of the frame cannot look like a new start edge.
    fork
      send(8'hF3, 1'b1);
      begin
        tick(5 * N + H);
        mask_data = 1'b1;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midreset_busy", {31'd0, busy}, 0);
        check("midreset_data", {24'd0, data}, 0);
        last_good = 8'h00;
        tick(1);
        mask_data = 1'b0;
      end
    join
    wait_quiet();
    send_exp(8'hA5);
    wait_quiet();
    check("data_after_reset_A5", {24'd0, data}, 32'hA5);

    // With rx_en low for a whole frame, nothing is received.
    rx_en = 1'b0;
    busy_cycles = 0;
    send(8'hFF, 1'b1);
    tick(N);
    check("disabled_no_busy", busy_cycles, 0);
    rx_en = 1'b1;
    tick(4);

    // Dropping rx_en mid-frame must not abort the frame.
    e.byte_v = 8'h81;
    e.ferr   = 1'b0;
    sb_q.push_back(e);
    fork
      send(8'h81, 1'b1);
      begin
        tick(3 * N + H);
        rx_en = 1'b0;
      end
    join
    wait_quiet();
    rx_en = 1'b1;
    check("data_after_81", {24'd0, data}, 32'h81);

    // Loopback-style burst, back to back.
    send_exp(8'h00);
    send_exp(8'hFF);
    send_exp(8'h55);
    send_exp(8'hAA);
    wait_quiet();
    check("data_after_burst", {24'd0, data}, 32'hAA);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
